// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 multi-channel convolution with two line
// buffers. One shared signed 3x3 filter is applied to every channel, and the
// cross-channel sum is emitted for each unpadded output position.
// Optional feature macro: CONV_SAT_EN. When it is defined, the sum is clamped
// to the OUT_W signed range. When it is undefined, the sum wraps to its low
// OUT_W bits.
// Handshake: a beat moves on an interface on every rising edge where valid
// and ready are both high. s_ready equals the global enable
// (!m_valid || m_ready). m_data and m_last hold while m_valid is high and
// m_ready is low.
module conv3x3_stream #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CH    = 3,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int OUT_W = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    coef_we,
    input  logic [3:0]              coef_addr,
    input  logic signed [CW-1:0]    coef_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_sof,
    input  logic [CH*DW-1:0]        s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_data,
    output logic                    m_last
);
    localparam int PW    = DW + CW + 1;
    localparam int NP    = 9 * CH;
    localparam int ACC_W = PW + $clog2(NP);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic en, acc;
    logic [COL_W-1:0] col_q, col_d, pos_col;
    logic [ROW_W-1:0] row_q, row_d, pos_row;
    logic [CH*DW-1:0] near_mem [IMG_W];   // row - 1
    logic [CH*DW-1:0] far_mem  [IMG_W];   // row - 2
    logic [CH*DW-1:0] tap_near, tap_far;
    logic [CH*DW-1:0] win_q [3][3];
    logic [CH*DW-1:0] win_d [3][3];
    logic wv_q, wv_d, wl_q, wl_d;
    logic signed [PW-1:0] prod_q [NP];
    logic signed [PW-1:0] prod_d [NP];
    logic pv_q, pv_d, pl_q, pl_d;
    logic signed [CW-1:0] coef_q [9];
    logic signed [CW-1:0] coef_d [9];
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] red;
    logic m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic signed [OUT_W-1:0] m_data_q, m_data_d;

    assign en       = !m_valid_q || m_ready;
    assign acc      = s_valid && en;
    assign s_ready  = en;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign tap_near = near_mem[pos_col];
    assign tap_far  = far_mem[pos_col];

    // Position of the incoming pixel (s_sof forces 0,0) and raster advance.
    always_comb begin
        pos_col = s_sof ? '0 : col_q;
        pos_row = s_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (acc) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end
        end
    end

    // Line buffers shift one row down per column visit; contents need no reset.
    always_ff @(posedge clk) begin
        if (acc) begin
            far_mem[pos_col]  <= tap_near;
            near_mem[pos_col] <= s_data;
        end
    end

    // Window shift, coefficient writes and the per-stage next values.
    always_comb begin
        win_d  = win_q;
        coef_d = coef_q;
        wv_d   = wv_q;
        wl_d   = wl_q;
        pv_d   = pv_q;
        pl_d   = pl_q;
        prod_d = prod_q;
        if (acc) begin
            for (int k = 0; k < 3; k++) begin
                win_d[k][0] = win_q[k][1];
                win_d[k][1] = win_q[k][2];
            end
            win_d[0][2] = tap_far;
            win_d[1][2] = tap_near;
            win_d[2][2] = s_data;
        end
        if (en) begin
            wv_d = acc && (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));
            wl_d = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
            pv_d = wv_q;
            pl_d = wl_q;
            for (int k = 0; k < 3; k++) begin
                for (int l = 0; l < 3; l++) begin
                    for (int c = 0; c < CH; c++) begin
                        prod_d[(k*3+l)*CH+c] = PW'($signed({1'b0, win_q[k][l][c*DW +: DW]}))
                                             * PW'(coef_q[k*3+l]);
                    end
                end
            end
        end
        for (int i = 0; i < 9; i++) begin
            if (coef_we && (coef_addr == 4'(i))) coef_d[i] = coef_data;
        end
    end

    // Adder tree, reduction to OUT_W and the output register next values.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NP; i++) sum = sum + ACC_W'(prod_q[i]);
`ifdef CONV_SAT_EN
        if (sum > ACC_W'($signed({1'b0, {(OUT_W-1){1'b1}}})))
            red = $signed({1'b0, {(OUT_W-1){1'b1}}});
        else if (sum < ACC_W'($signed({1'b1, {(OUT_W-1){1'b0}}})))
            red = $signed({1'b1, {(OUT_W-1){1'b0}}});
        else
            red = sum[OUT_W-1:0];
`else
        red = sum[OUT_W-1:0];
`endif
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (en) begin
            m_valid_d = pv_q;
            if (pv_q) begin
                m_data_d = red;
                m_last_d = pl_q;
            end
        end
    end

`ifndef CONV_SAT_EN
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum[ACC_W-1:OUT_W];
`endif

    // State registers: counters, window, products, coefficients, outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= '{default: '0};
            wv_q      <= 1'b0;
            wl_q      <= 1'b0;
            prod_q    <= '{default: '0};
            pv_q      <= 1'b0;
            pl_q      <= 1'b0;
            coef_q    <= '{default: '0};
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            win_q     <= win_d;
            wv_q      <= wv_d;
            wl_q      <= wl_d;
            prod_q    <= prod_d;
            pv_q      <= pv_d;
            pl_q      <= pl_d;
            coef_q    <= coef_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end
endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming, parametrised 3x3 multi-channel convolution engine, the successor to the fixed-size frame-buffered convolution block. Accepts one raster-order pixel per handshake and keeps two line buffers plus a 3x3 window instead of storing the whole frame. It applies one shared signed 3x3 filter to every channel and emits the cross-channel sum per valid (unpadded) output position over a valid/ready stream. It sits between the pixel source and the downstream feature/post-processing stage.

## Interface
- IMG_W, 8: pixels per row; must be >= 3
- IMG_H, 8: rows per frame; must be >= 3
- CH, 3: channels per pixel
- DW, 8: unsigned pixel width per channel
- CW, 8: signed coefficient width
- OUT_W, 9: signed output width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  coefficient index k*3+l (0..8); 9..15 ignored
- coef_data  in  CW  signed coefficient
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_sof  in  1  start of frame, qualified by s_valid
- s_data  in  CH*DW  channel c at bits [c*DW +: DW]
- m_valid  out  1  output valid
- m_ready  in  1  downstream ready
- m_data  out  OUT_W  signed convolution result
- m_last  out  1  last output of the frame

## Operation
- Internal counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next accepted pixel. Both reset to 0 and advance on each accepted pixel in raster order. After (IMG_H-1, IMG_W-1) both wrap to 0.
- An accepted pixel with s_sof=1 is taken as position (0,0), whatever the counters hold. Following pixels continue from (0,1).
- Line buffers hold the previous two rows, all channels. They are not reset, and stale contents are never used because no output is produced for row<2.
- Window: an output is generated for an accepted pixel at (row, col) with row>=2 and col>=2. The window covers rows row-2..row and columns col-2..col, and FILTER[k][l] multiplies pixel (row-2+k, col-2+l). This gives (IMG_W-2)*(IMG_H-2) outputs per frame. m_last=1 on the output generated by pixel (IMG_H-1, IMG_W-1).
- Arithmetic: each pixel is zero-extended and multiplied by its signed coefficient, giving a DW+CW+1 bit product. All 9*CH products are summed exactly in ACC_W = DW+CW+1+clog2(9*CH) bits. ACC_W is then reduced to OUT_W as set under Configuration.
- Coefficients: 9 registers, reset to 0. A write at cycle t is used by every product computed from cycle t+1 onward. Writes mid-frame are legal, and windows already in the pipeline keep the values they captured.
- Pipeline: stage 1 registers the window and the 9*CH products. Stage 2 registers the adder tree, the reduction, m_data and m_last.
- Flow control: the global enable is en = !m_valid || m_ready, and s_ready = en. When en=0 all stages and counters hold, and m_data and m_last stay stable while m_valid=1.

## Timing
- Reset values: s_ready=1, m_valid=0, m_data=0, m_last=0, row=col=0, coefficients 0, pipeline valid bits 0.
- Latency: a window-completing pixel accepted at edge t gives m_valid=1 after edge t+2, when there is no backpressure.
- Throughput is 1 pixel per cycle. Within a row, outputs are back-to-back.
- Reset asserted mid-frame clears the pipeline immediately and drops in-flight outputs. The first pixel after release is position (0,0).
- When s_sof arrives mid-frame, in-flight outputs still complete. No further outputs come from the aborted frame.
- When m_ready and s_valid change on the same cycle, only the en computed in that cycle applies.

## Configuration
- CONV_SAT_EN defined: the ACC_W sum is clamped to the signed range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- CONV_SAT_EN undefined: the sum is truncated to its low OUT_W bits (two's-complement wrap), which is the legacy behaviour.

## Test plan
- Reset: hold rst_n=0 with random inputs. Required: s_ready=1, m_valid=0, m_data=0. Release, then first pixel (no s_sof) is treated as (0,0).
- IMG_W=IMG_H=4, CH=3, all coefficients 1, every channel 1. Required: 4 outputs of 27, m_last only on the 4th, first output 2 cycles after pixel (2,2).
- Identity kernel (coef 4 = 1, others 0), channel values (r,g,b)=(x, 2x, 3x) with x = row*4+col. Required: output 6x for the centre pixel, e.g. 30 for centre (1,1) (x=5).
- Backpressure: drop m_ready for 5 cycles mid-row. Required: s_ready=0 and m_data/m_last held throughout, no lost or duplicated outputs, and the sequence matches the no-stall golden model.
- All coefficients 127, all pixels 255, CH=3, OUT_W=9. Required: m_data=255 with CONV_SAT_EN, -101 (874395 wrapped) without it.
- Assert s_sof on the pixel at (3,1) of a frame. Required: counters restart and the next outputs come from the new frame's (2,2). Separately, reset pulsed mid-frame leaves no m_valid until 2 cycles after the new (2,2).
